// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory bus arbiter.
//   state_e : arbiter FSM states
//   owner_e : requester identity (CPU load/store port, debug/DMA port)
//   BANK_*  : decoder bank-select codes; 2'b11 is unmapped
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    localparam logic [1:0] BANK_DATA = 2'b00;
    localparam logic [1:0] BANK_VGA  = 2'b01;
    localparam logic [1:0] BANK_IO   = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter for the memory bus.
//   clk, rst_n   : clock, async active-low reset
//   req_cpu_i    : CPU request
//   req_dbg_i    : debug/DMA request
//   accept_i     : the grant is being taken this cycle; updates last owner
//   gnt_valid_o  : at least one request pending
//   gnt_owner_o  : winning requester
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   req_cpu_i,
    input  logic   req_dbg_i,
    input  logic   accept_i,
    output logic   gnt_valid_o,
    output owner_e gnt_owner_o
);

    owner_e last_owner_q;
    owner_e last_owner_d;

    always_comb begin
        gnt_valid_o = req_cpu_i | req_dbg_i;
        if (req_cpu_i && req_dbg_i) begin
            // On contention the requester served least recently wins.
            gnt_owner_o = (last_owner_q == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end else if (req_cpu_i) begin
            gnt_owner_o = OWN_CPU;
        end else begin
            gnt_owner_o = OWN_DBG;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        if (accept_i && gnt_valid_o) begin
            last_owner_d = gnt_owner_o;
        end
    end

    // Reset to DBG so the CPU wins the first contended arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= OWN_DBG;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Data-memory bus arbiter between the CPU load/store port and the debug/DMA
// port. Drives address/strobes into the memory decoder, inserts per-bank wait
// states and returns a one-cycle ack with error flag and read data.
//   cpu_* / dbg_*         : requester ports (req/we/addr/wdata in, ack/err/rdata out)
//   mem_addr, mem_wdata   : latched address/data toward the decoder and banks
//   mem_read, mem_write   : strobes, held for every ACCESS cycle
//   dec_bank, dec_invalid : decoder feedback
//   mem_rdata             : bank read data
//   busy                  : FSM not idle
//
// state  | meaning
// IDLE   | waiting for a request, arbitration happens here
// ACCESS | strobes driven, wait-state counter running
// RESP   | one-cycle ack to the owner
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned WAIT_DATA = 0,
    parameter int unsigned WAIT_VGA  = 1,
    parameter int unsigned WAIT_IO   = 2,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic [31:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic        dbg_err,
    output logic [31:0] dbg_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [1:0]  dec_bank,
    input  logic        dec_invalid,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    localparam logic [CNT_W-1:0] WAIT_DATA_C = CNT_W'(WAIT_DATA);
    localparam logic [CNT_W-1:0] WAIT_VGA_C  = CNT_W'(WAIT_VGA);
    localparam logic [CNT_W-1:0] WAIT_IO_C   = CNT_W'(WAIT_IO);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              first_q, first_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              gnt_valid;
    owner_e            gnt_owner;
    logic              arb_accept;
    logic [CNT_W-1:0]  bank_wait;

    assign arb_accept = (state_q == IDLE);

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_cpu_i   (cpu_req),
        .req_dbg_i   (dbg_req),
        .accept_i    (arb_accept),
        .gnt_valid_o (gnt_valid),
        .gnt_owner_o (gnt_owner)
    );

    always_comb begin
        case (dec_bank)
            BANK_DATA: bank_wait = WAIT_DATA_C;
            BANK_VGA:  bank_wait = WAIT_VGA_C;
            BANK_IO:   bank_wait = WAIT_IO_C;
            default:   bank_wait = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d = gnt_owner;
                    we_d    = (gnt_owner == OWN_CPU) ? cpu_we    : dbg_we;
                    addr_d  = (gnt_owner == OWN_CPU) ? cpu_addr  : dbg_addr;
                    wdata_d = (gnt_owner == OWN_CPU) ? cpu_wdata : dbg_wdata;
                    first_d = 1'b1;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                first_d = 1'b0;
                if (first_q && (dec_invalid || dec_bank == 2'b11)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (first_q) begin
                    // The freshly selected wait count is tested in the same
                    // cycle so a zero-wait bank acks two cycles after req.
                    if (bank_wait == '0) begin
                        rdata_d = we_q ? '0 : mem_rdata;
                        state_d = RESP;
                    end else begin
                        cnt_d = bank_wait - CNT_ONE;
                    end
                end else if (cnt_q == '0) begin
                    rdata_d = we_q ? '0 : mem_rdata;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes and acks decode straight from the state register so an async
    // reset removes them without waiting for a clock.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = (state_q == ACCESS) && !we_q;
    assign mem_write = (state_q == ACCESS) && we_q;
    assign busy      = (state_q != IDLE);

    assign cpu_ack   = (state_q == RESP) && (owner_q == OWN_CPU);
    assign dbg_ack   = (state_q == RESP) && (owner_q == OWN_DBG);
    assign cpu_err   = cpu_ack && err_q;
    assign dbg_err   = dbg_ack && err_q;
    assign cpu_rdata = cpu_ack ? rdata_q : '0;
    assign dbg_rdata = dbg_ack ? rdata_q : '0;

endmodule
